// File: rtl/mac_pkg.sv
// Shared sizing functions and saturation bounds for the pipelined MAC datapath.
package mac_pkg;

    typedef logic signed [63:0] wide_t;

    function automatic int acc_width(input int width, input int taps);
        return 2 * width + $clog2(taps);
    endfunction

    function automatic int tap_cnt_width(input int taps);
        return $clog2(taps);
    endfunction

    function automatic wide_t sat_max(input int w);
        wide_t one;
        one = 64'sd1;
        return (one <<< (2 * w - 1)) - 64'sd1;
    endfunction

    function automatic wide_t sat_min(input int w);
        wide_t one;
        one = 64'sd1;
        return -(one <<< (2 * w - 1));
    endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Signed WIDTH x WIDTH multiplier with STAGES product registers, each carrying a valid bit.
module mac_mult_pipe #(
    parameter int WIDTH  = 14,
    parameter int STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic                      out_valid,
    output logic signed [2*WIDTH-1:0] out_prod
);

    localparam int PW = 2 * WIDTH;

    logic signed [PW-1:0] prod_d [STAGES];
    logic signed [PW-1:0] prod_q [STAGES];
    logic [STAGES-1:0]    vld_d;
    logic [STAGES-1:0]    vld_q;
    logic signed [PW-1:0] prod_in;

    assign prod_in = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        prod_d = prod_q;
        vld_d  = vld_q;
        if (flush) begin
            vld_d = '0;
        end else if (en) begin
            prod_d[0] = prod_in;
            vld_d[0]  = in_valid;
            for (int i = 1; i < STAGES; i++) begin
                prod_d[i] = prod_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every stage samples its predecessor's old value.
        // NOTE: the product data registers are cleared too, so the whole pipeline reads zero after reset, not just the valid bits.
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            prod_q <= prod_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_prod  = prod_q[STAGES-1];

endmodule

// File: rtl/mac_pipe_acc.sv
// Pipelined MAC: multiplier pipe feeding a TAPS-long windowed accumulator with a registered,
// optionally saturating, valid/ready output.
module mac_pipe_acc
    import mac_pkg::*;
#(
    parameter int WIDTH       = 14,
    parameter int MULT_STAGES = 2,
    parameter int TAPS        = 8,
    parameter int SATURATE    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*WIDTH-1:0] out_data,
    output logic                      out_sat
);

    localparam int    OUT_W   = 2 * WIDTH;
    localparam int    ACC_W   = acc_width(WIDTH, TAPS);
    localparam int    CNT_W   = tap_cnt_width(TAPS);
    localparam wide_t SAT_MAX = sat_max(WIDTH);
    localparam wide_t SAT_MIN = sat_min(WIDTH);

    typedef logic [CNT_W-1:0] tap_cnt_t;
    localparam tap_cnt_t LAST_TAP = tap_cnt_t'(TAPS - 1);

    logic                    stall;
    logic                    p_valid;
    logic signed [OUT_W-1:0] p_data;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    wide_t                   sum_wide;
    logic                    sat_hi;
    logic                    sat_lo;
    logic signed [OUT_W-1:0] conv_data;
    logic                    conv_sat;

    logic signed [ACC_W-1:0] acc_d, acc_q;
    tap_cnt_t                cnt_d, cnt_q;
    logic                    out_valid_d, out_valid_q;
    logic signed [OUT_W-1:0] out_data_d, out_data_q;
    logic                    out_sat_d, out_sat_q;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall && !clear;

    mac_mult_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (MULT_STAGES)
    ) u_mult (
        .clk       (clk),
        .reset     (reset),
        .en        (!stall),
        .flush     (clear),
        .in_valid  (in_valid && in_ready),
        .a         (a),
        .b         (b),
        .out_valid (p_valid),
        .out_prod  (p_data)
    );

    assign prod_ext = {{(ACC_W - OUT_W){p_data[OUT_W-1]}}, p_data};
    assign sum      = (cnt_q == '0) ? prod_ext : acc_q + prod_ext;
    assign sum_wide = {{($bits(wide_t) - ACC_W){sum[ACC_W-1]}}, sum};

    always_comb begin
        sat_hi    = sum_wide > SAT_MAX;
        sat_lo    = sum_wide < SAT_MIN;
        conv_sat  = sat_hi || sat_lo;
        conv_data = sum[OUT_W-1:0];
        if (SATURATE != 0) begin
            if (sat_hi) begin
                conv_data = SAT_MAX[OUT_W-1:0];
            end else if (sat_lo) begin
                conv_data = SAT_MIN[OUT_W-1:0];
            end
        end
    end

    // The handshake retires the held result even when clear arrives in the same cycle.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (!stall && p_valid) begin
            acc_d = sum;
            if (cnt_q == LAST_TAP) begin
                cnt_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = conv_data;
                out_sat_d   = conv_sat;
            end else begin
                cnt_d = cnt_q + tap_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_pipe_acc.sv
// Bench for mac_pipe_acc: saturating and wrapping instances driven in parallel, checked each cycle
// against a queue-based window model, plus directed scenarios with literal expectations.
module tb_mac_pipe_acc;

    localparam int     WIDTH   = 14;
    localparam int     MS      = 2;
    localparam int     TAPS    = 4;
    localparam longint OUT_MAX = (64'sd1 <<< 27) - 64'sd1;
    localparam longint OUT_MIN = -(64'sd1 <<< 27);

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic clear     = 1'b0;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b1;
    logic signed [WIDTH-1:0] a = '0;
    logic signed [WIDTH-1:0] b = '0;

    logic                      in_ready_s, out_valid_s, out_sat_s;
    logic signed [2*WIDTH-1:0] out_data_s;
    logic                      in_ready_w, out_valid_w, out_sat_w;
    logic signed [2*WIDTH-1:0] out_data_w;

    always #5 clk = ~clk;

    mac_pipe_acc #(.WIDTH(WIDTH), .MULT_STAGES(MS), .TAPS(TAPS), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_sat(out_sat_s)
    );

    mac_pipe_acc #(.WIDTH(WIDTH), .MULT_STAGES(MS), .TAPS(TAPS), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready),
        .out_data(out_data_w), .out_sat(out_sat_w)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic longint clamp(input longint s);
        if (s > OUT_MAX) return OUT_MAX;
        if (s < OUT_MIN) return OUT_MIN;
        return s;
    endfunction

    function automatic longint wrap(input longint s);
        logic signed [2*WIDTH-1:0] t;
        t = s[2*WIDTH-1:0];
        return longint'(t);
    endfunction

    // Behavioural model: each accepted product needs MS unstalled edges to reach the window sum.
    typedef struct { longint p; int rem; } flight_t;
    flight_t flight[$];
    longint  win_sum = 0;
    int      win_n   = 0;
    bit      m_ov    = 1'b0;
    longint  m_sum   = 0;
    bit      live    = 1'b0;
    int      cyc     = 0;
    int      last_acc_cyc = 0;
    int      rise_cyc     = 0;

    always @(posedge clk) begin
        bit stall;
        if (reset) begin
            flight.delete();
            win_sum = 0;
            win_n   = 0;
            m_ov    = 1'b0;
            m_sum   = 0;
            live    = 1'b1;
        end else if (live) begin
            stall = m_ov && !out_ready;
            if (clear) begin
                flight.delete();
                win_sum = 0;
                win_n   = 0;
                if (m_ov && out_ready) m_ov = 1'b0;
            end else if (!stall) begin
                m_ov = 1'b0;
                foreach (flight[i]) flight[i].rem--;
                if (flight.size() > 0 && flight[0].rem == 0) begin
                    win_sum += flight[0].p;
                    win_n++;
                    void'(flight.pop_front());
                    if (win_n == TAPS) begin
                        m_ov    = 1'b1;
                        m_sum   = win_sum;
                        win_sum = 0;
                        win_n   = 0;
                    end
                end
                if (in_valid) begin
                    flight.push_back('{longint'(a) * longint'(b), MS});
                    last_acc_cyc = cyc;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (live) begin
            check("in_ready_sat", longint'(in_ready_s), longint'(!(m_ov && !out_ready) && !clear));
            check("in_ready_wrap", longint'(in_ready_w), longint'(!(m_ov && !out_ready) && !clear));
            check("out_valid_sat", longint'(out_valid_s), longint'(m_ov));
            check("out_valid_wrap", longint'(out_valid_w), longint'(m_ov));
            if (m_ov) begin
                check("data_sat", longint'(out_data_s), clamp(m_sum));
                check("flag_sat", longint'(out_sat_s), longint'(m_sum > OUT_MAX || m_sum < OUT_MIN));
                check("data_wrap", longint'(out_data_w), wrap(m_sum));
                check("flag_wrap", longint'(out_sat_w), longint'(m_sum > OUT_MAX || m_sum < OUT_MIN));
            end
        end
    end

    longint cap_sat[$];
    longint cap_flag[$];
    longint cap_wrap[$];
    logic   prev_ov = 1'b0;

    always @(negedge clk) begin
        if (out_valid_s === 1'b1 && prev_ov !== 1'b1) rise_cyc = cyc;
        prev_ov = out_valid_s;
        if (out_valid_s === 1'b1 && out_ready) begin
            cap_sat.push_back(longint'(out_data_s));
            cap_flag.push_back(longint'(out_sat_s));
            cap_wrap.push_back(longint'(out_data_w));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_sat.delete();
        cap_flag.delete();
        cap_wrap.delete();
    endtask

    task automatic send(input int av, input int bv);
        int  n    = 0;
        bit  done = 1'b0;
        in_valid = 1'b1;
        a = WIDTH'(av);
        b = WIDTH'(bv);
        while (!done && n <= 100) begin
            @(negedge clk);
            done = in_ready_s;
            step();
            n++;
        end
        if (!done) check("send_bound", longint'(n), 0);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k = 0;
        while (cap_sat.size() < n && k < 80) begin
            step();
            k++;
        end
        check("result_count", longint'(cap_sat.size()), longint'(n));
    endtask

    task automatic wait_valid();
        int k = 0;
        @(negedge clk);
        while (out_valid_s !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("valid_seen", longint'(out_valid_s === 1'b1), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, longint'(out_valid_s), 0);
        check({tag, "_out_data"}, longint'(out_data_s), 0);
        check({tag, "_out_sat"}, longint'(out_sat_s), 0);
        check({tag, "_in_ready"}, longint'(in_ready_s), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;

        step();
        step();
        reset = 1'b0;
        check_idle_outputs("reset0");
        step();

        // Single window: 1*2+2*2+3*2+4*2 = 20, visible MS+1 cycles after the last accept.
        clear_caps();
        for (int i = 1; i <= 4; i++) send(i, 2);
        wait_results(1);
        if (cap_sat.size() >= 1) begin
            check("win_sum", cap_sat[0], 20);
            check("win_flag", cap_flag[0], 0);
        end
        check("latency", longint'(rise_cyc - last_acc_cyc), MS + 1);

        // Back-to-back windows with no input bubble.
        clear_caps();
        c0 = cyc;
        for (int i = 1; i <= 8; i++) send(i, 1);
        check("b2b_cycles", longint'(cyc - c0), 8);
        wait_results(2);
        if (cap_sat.size() >= 2) begin
            check("b2b_first", cap_sat[0], 10);
            check("b2b_second", cap_sat[1], 26);
        end

        // Saturation: 4 * 8192^2 = 2^28.
        clear_caps();
        for (int i = 0; i < 4; i++) send(-8192, -8192);
        wait_results(1);
        if (cap_sat.size() >= 1) begin
            check("sat_data", cap_sat[0], 134217727);
            check("sat_flag", cap_flag[0], 1);
            check("wrap_data", cap_wrap[0], 0);
        end
        check("wrap_flag", longint'(out_sat_w), 1);

        // Backpressure: first result held for 5 cycles while the next window queues up.
        clear_caps();
        fork
            begin
                for (int i = 1; i <= 8; i++) send(i, 1);
            end
            begin
                out_ready = 1'b0;
                wait_valid();
                for (int k = 0; k < 5; k++) begin
                    check("bp_in_ready", longint'(in_ready_s), 0);
                    check("bp_hold_valid", longint'(out_valid_s), 1);
                    check("bp_hold_data", longint'(out_data_s), 10);
                    step();
                    if (k < 4) @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        wait_results(2);
        if (cap_sat.size() >= 2) begin
            check("bp_first", cap_sat[0], 10);
            check("bp_second", cap_sat[1], 26);
        end

        // Clear mid-window: the two early taps and the input offered with clear are discarded.
        clear_caps();
        send(9, 9);
        send(9, 9);
        in_valid = 1'b1;
        a = 7;
        b = 7;
        clear = 1'b1;
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) send(5, 1);
        wait_results(1);
        repeat (10) step();
        check("clr_count", longint'(cap_sat.size()), 1);
        if (cap_sat.size() >= 1) check("clr_sum", cap_sat[0], 20);

        // Clear while a result is pending keeps that result.
        clear_caps();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(i, 2);
        wait_valid();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        @(negedge clk);
        check("clr_pend_valid", longint'(out_valid_s), 1);
        check("clr_pend_data", longint'(out_data_s), 20);
        step();
        out_ready = 1'b1;
        wait_results(1);
        if (cap_sat.size() >= 1) check("clr_pend_taken", cap_sat[0], 20);

        // Reset mid-window, then reset during a stall, then a clean window.
        clear_caps();
        send(3, 3);
        send(3, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle_outputs("rst_mid");
        step();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(i, 1);
        wait_valid();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle_outputs("rst_stall");
        step();
        out_ready = 1'b1;
        clear_caps();
        for (int i = 1; i <= 4; i++) send(i, 2);
        wait_results(1);
        if (cap_sat.size() >= 1) check("rst_after", cap_sat[0], 20);

        // Randomised traffic, checked every cycle against the model.
        for (int k = 0; k < 3000; k++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 75);
            clear     = ($urandom_range(0, 99) < 3);
            reset     = ($urandom_range(0, 999) < 5);
            if ($urandom_range(0, 3) == 0) begin
                a = ($urandom_range(0, 1) == 1) ? 14'sh2000 : 14'sh1fff;
                b = ($urandom_range(0, 1) == 1) ? 14'sh2000 : 14'sh1fff;
            end else begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
            end
            step();
        end
        in_valid  = 1'b0;
        clear     = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
